control_sequencer: RTL

//  Parametrised T-step control unit for the bus-based CPU datapath.
//  It fetches an instruction, decodes IR, and drives the one-hot register In/Out/Select and datapath strobes.

---
 rtl/ctrl_seq_pkg.sv | 60 ++++++
 rtl/control_sequencer_ir_decode.sv | 51 +++++
 rtl/control_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_seq_pkg.sv
// rtl/ctrl_seq_pkg.sv - state, opcode and ALU encodings shared by the control sequencer
package ctrl_seq_pkg;

  // Step encodings; IDLE reads as 0 so a reset sequencer shows step=0
  typedef enum logic [3:0] {
    S_IDLE = 4'h0,
    S_T0   = 4'h1,
    S_T1   = 4'h2,
    S_T2   = 4'h3,
    S_T3   = 4'h4,
    S_T4   = 4'h5,
    S_T5   = 4'h6,
    S_T6   = 4'h7,
    S_HALT = 4'hF
  } state_e;

  typedef enum logic [1:0] {
    CLS_ALU3    = 2'd0,
    CLS_MULDIV  = 2'd1,
    CLS_ILLEGAL = 2'd2
  } op_class_e;

  localparam int OPCODE_W   = 5;
  localparam int ALU_CODE_W = 4;

  localparam logic [OPCODE_W-1:0] OP_ADD = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUB = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_AND = 5'b00101;
  localparam logic [OPCODE_W-1:0] OP_OR  = 5'b00110;
  localparam logic [OPCODE_W-1:0] OP_SHR = 5'b00111;
  localparam logic [OPCODE_W-1:0] OP_SHL = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_MUL = 5'b01111;
  localparam logic [OPCODE_W-1:0] OP_DIV = 5'b10000;

  // ALU_NOP is what alu_op shows outside T4
  localparam logic [ALU_CODE_W-1:0] ALU_NOP = 4'd0;
  localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'd1;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'd2;
  localparam logic [ALU_CODE_W-1:0] ALU_AND = 4'd3;
  localparam logic [ALU_CODE_W-1:0] ALU_OR  = 4'd4;
  localparam logic [ALU_CODE_W-1:0] ALU_SHR = 4'd5;
  localparam logic [ALU_CODE_W-1:0] ALU_SHL = 4'd6;
  localparam logic [ALU_CODE_W-1:0] ALU_MUL = 4'd7;
  localparam logic [ALU_CODE_W-1:0] ALU_DIV = 4'd8;

  function automatic logic [ALU_CODE_W-1:0] opcode_to_alu(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_SHR:  return ALU_SHR;
      OP_SHL:  return ALU_SHL;
      OP_MUL:  return ALU_MUL;
      OP_DIV:  return ALU_DIV;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_ir_decode.sv
// rtl/control_sequencer_ir_decode.sv - combinational IR field split and opcode classification
module ir_decode
  import ctrl_seq_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4,
  parameter int INSTR_W   = 32,
  parameter int ALU_OP_W  = 4
) (
  input  logic [INSTR_W-1:0]   ir,
  output op_class_e            op_class,
  output logic [REG_IDX_W-1:0] ra,
  output logic [REG_IDX_W-1:0] rb,
  output logic [REG_IDX_W-1:0] rc,
  output logic [ALU_OP_W-1:0]  alu_op,
  output logic                 illegal
);

  logic [OPCODE_W-1:0] opcode;
  logic                idx_bad;
  logic                unused_ir_bits;

  assign opcode = ir[INSTR_W-1 -: OPCODE_W];
  assign ra     = ir[INSTR_W-OPCODE_W-1 -: REG_IDX_W];
  assign rb     = ir[INSTR_W-OPCODE_W-REG_IDX_W-1 -: REG_IDX_W];
  assign rc     = ir[INSTR_W-OPCODE_W-2*REG_IDX_W-1 -: REG_IDX_W];
  assign alu_op = ALU_OP_W'(opcode_to_alu(opcode));

  // Immediate/offset bits are not used by any sequenced instruction
  assign unused_ir_bits = ^ir[INSTR_W-OPCODE_W-3*REG_IDX_W-1:0];

  // Classify opcode; only register fields the class actually uses are range-checked
  always_comb begin
    op_class = CLS_ILLEGAL;
    idx_bad  = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: begin
        op_class = CLS_ALU3;
        idx_bad  = (int'(ra) >= NUM_REGS) || (int'(rb) >= NUM_REGS) || (int'(rc) >= NUM_REGS);
      end
      OP_MUL, OP_DIV: begin
        op_class = CLS_MULDIV;
        idx_bad  = (int'(ra) >= NUM_REGS) || (int'(rb) >= NUM_REGS);
      end
      default: op_class = CLS_ILLEGAL;
    endcase
  end

  assign illegal = (op_class == CLS_ILLEGAL) || idx_bad;

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - T-step fetch/decode/execute control FSM; CTRL_SINGLE_STEP_EN adds step_req gating
module control_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int INSTR_W  = 32,
  parameter int ALU_OP_W = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
`ifdef CTRL_SINGLE_STEP_EN
  input  logic                step_req,
`endif
  input  logic [INSTR_W-1:0]  ir,
  input  logic                mem_rdy,
  output logic [NUM_REGS-1:0] reg_in,
  output logic [NUM_REGS-1:0] reg_out,
  output logic                pc_out,
  output logic                pc_in,
  output logic                inc_pc,
  output logic                mar_in,
  output logic                md_read,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                y_in,
  output logic                zlo_in,
  output logic                zhi_in,
  output logic                zlo_out,
  output logic                zhi_out,
  output logic                lo_in,
  output logic                hi_in,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [3:0]          step,
  output logic                busy,
  output logic                illegal,
  output logic                bus_err
);

  localparam int REG_IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int WAIT_W    = $clog2(WAIT_MAX + 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                illegal_q, illegal_d;
  logic                bus_err_q, bus_err_d;
  logic                adv;

  op_class_e           dec_class;
  logic [REG_IDX_W-1:0] dec_ra, dec_rb, dec_rc;
  logic [ALU_OP_W-1:0] dec_alu;
  logic                dec_illegal;

`ifdef CTRL_SINGLE_STEP_EN
  assign adv = step_req;
`else
  assign adv = 1'b1;
`endif

  ir_decode #(
    .NUM_REGS  (NUM_REGS),
    .REG_IDX_W (REG_IDX_W),
    .INSTR_W   (INSTR_W),
    .ALU_OP_W  (ALU_OP_W)
  ) u_ir_decode (
    .ir       (ir),
    .op_class (dec_class),
    .ra       (dec_ra),
    .rb       (dec_rb),
    .rc       (dec_rc),
    .alu_op   (dec_alu),
    .illegal  (dec_illegal)
  );

  // State, T1 wait counter and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state: everything holds on a cycle where the sequencer may not advance
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    if (adv) begin
      case (state_q)
        S_IDLE: if (run) state_d = S_T0;
        S_T0: begin
          state_d = S_T1;
          wait_d  = '0;
        end
        S_T1: begin
          if (mem_rdy) begin
            state_d = S_T2;
            wait_d  = '0;
          end else if (wait_q == WAIT_W'(WAIT_MAX - 1)) begin
            state_d   = S_HALT;
            bus_err_d = 1'b1;
            wait_d    = '0;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end
        S_T2: state_d = S_T3;
        S_T3: begin
          if (dec_illegal) begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end else begin
            state_d = S_T4;
          end
        end
        S_T4: state_d = S_T5;
        S_T5: begin
          if (dec_class == CLS_MULDIV) state_d = S_T6;
          else                         state_d = run ? S_T0 : S_IDLE;
        end
        S_T6:   state_d = run ? S_T0 : S_IDLE;
        S_HALT: state_d = S_HALT;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Moore control decode; T3..T6 select registers from the IR latched during T2
  always_comb begin
    reg_in  = '0;
    reg_out = '0;
    pc_out  = 1'b0;
    pc_in   = 1'b0;
    inc_pc  = 1'b0;
    mar_in  = 1'b0;
    md_read = 1'b0;
    mdr_in  = 1'b0;
    mdr_out = 1'b0;
    ir_in   = 1'b0;
    y_in    = 1'b0;
    zlo_in  = 1'b0;
    zhi_in  = 1'b0;
    zlo_out = 1'b0;
    zhi_out = 1'b0;
    lo_in   = 1'b0;
    hi_in   = 1'b0;
    alu_op  = '0;
    case (state_q)
      S_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        zlo_in = 1'b1;
      end
      S_T1: begin
        zlo_out = 1'b1;
        pc_in   = (wait_q == '0);
        md_read = 1'b1;
        mdr_in  = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        if (!dec_illegal) begin
          y_in    = 1'b1;
          reg_out = (dec_class == CLS_MULDIV) ? (NUM_REGS'(1) << dec_ra) : (NUM_REGS'(1) << dec_rb);
        end
      end
      S_T4: begin
        alu_op = dec_alu;
        zlo_in = 1'b1;
        if (dec_class == CLS_MULDIV) begin
          reg_out = NUM_REGS'(1) << dec_rb;
          zhi_in  = 1'b1;
        end else begin
          reg_out = NUM_REGS'(1) << dec_rc;
        end
      end
      S_T5: begin
        zlo_out = 1'b1;
        if (dec_class == CLS_MULDIV) lo_in = 1'b1;
        else                         reg_in = NUM_REGS'(1) << dec_ra;
      end
      S_T6: begin
        zhi_out = 1'b1;
        hi_in   = 1'b1;
      end
      default: ;
    endcase
  end

  assign step    = state_q;
  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

endmodule
